cla_pipe_add16: RTL and testbench

- 3-stage pipelined 16-bit carry-lookahead adder for the perceptron weighted-sum datapath.
- Stage 1 generates bit-level p/g, which the 4-bit lookahead carry networks consume.
- Stage 2 combines the four groups through a second-level lookahead.
- Stage 3 forms the sum and carry-out.
- Valid/ready handshake at both ends; a tag travels with each operand pair.

---
 rtl/cla_pipe_add16.sv | 188 ++++++++++++++++++
 tb/tb_cla_pipe_add16.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_add16.sv
// 3-stage pipelined 16-bit carry-lookahead adder with valid/ready handshake and tag sideband.
// Optional signed saturation and ovf_out port enabled by defining CLA_SAT_EN.
module cla_pipe_add16 #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout,
   output logic [TAG_W-1:0] tag_out
`ifdef CLA_SAT_EN
   ,
   output logic             ovf_out
`endif
);

   localparam int GROUPS = WIDTH / 4;

   // Carry-in of each bit inside one 4-bit group, all terms flattened
   function automatic logic [3:0] cla4_carry(input logic [3:0] p,
                                             input logic [3:0] g,
                                             input logic       ci);
      logic [3:0] c;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      return c;
   endfunction

   function automatic logic group_gen(input logic [3:0] p, input logic [3:0] g);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   logic             rdy1;
   logic             rdy2;
   logic             rdy3;

   logic             v1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             cin1;
   logic [TAG_W-1:0] tag1;

   logic             v2;
   logic [WIDTH-1:0] p2;
   logic [WIDTH-1:0] c2;
   logic             c16_2;
   logic [TAG_W-1:0] tag2;

   logic             v3;
   logic [WIDTH-1:0] sum3;
   logic             cout3;
   logic [TAG_W-1:0] tag3;

   logic [WIDTH-1:0] bit_p;
   logic [WIDTH-1:0] bit_g;
   logic [GROUPS-1:0] grp_g;
   logic [GROUPS-1:0] grp_p;
   logic [GROUPS:0]   grp_c;
   logic [WIDTH-1:0]  carry;
   logic [WIDTH-1:0]  sum_next;

`ifdef CLA_SAT_EN
   logic             a15_2;
   logic             ovf3;
   logic             ovf_next;
`endif

   // Global-advance chain: a bubble anywhere downstream lets upstream move
   assign rdy3     = !v3 | out_ready;
   assign rdy2     = !v2 | rdy3;
   assign rdy1     = !v1 | rdy2;
   assign in_ready = rdy1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         a1   <= '0;
         b1   <= '0;
         cin1 <= 1'b0;
         tag1 <= '0;
      end else if (rdy1) begin
         v1   <= in_valid;
         a1   <= a_in;
         b1   <= b_in;
         cin1 <= cin;
         tag1 <= tag_in;
      end
   end

   assign bit_p = a1 ^ b1;
   assign bit_g = a1 & b1;

   always_comb begin
      grp_g    = '0;
      grp_p    = '0;
      grp_c    = '0;
      carry    = '0;
      grp_c[0] = cin1;
      for (int unsigned k = 0; k < GROUPS; k++) begin
         grp_g[k]     = group_gen(bit_p[4*k +: 4], bit_g[4*k +: 4]);
         grp_p[k]     = &bit_p[4*k +: 4];
         grp_c[k + 1] = grp_g[k] | (grp_p[k] & grp_c[k]);
      end
      for (int unsigned k = 0; k < GROUPS; k++) begin
         carry[4*k +: 4] = cla4_carry(bit_p[4*k +: 4], bit_g[4*k +: 4], grp_c[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2    <= 1'b0;
         p2    <= '0;
         c2    <= '0;
         c16_2 <= 1'b0;
         tag2  <= '0;
      end else if (rdy2) begin
         v2    <= v1;
         p2    <= bit_p;
         c2    <= carry;
         c16_2 <= grp_c[GROUPS];
         tag2  <= tag1;
      end
   end

`ifdef CLA_SAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a15_2 <= 1'b0;
      end else if (rdy2) begin
         a15_2 <= a1[WIDTH-1];
      end
   end

   // Carries into and out of the sign bit disagree exactly on signed overflow
   always_comb begin
      ovf_next = c2[WIDTH-1] ^ c16_2;
      sum_next = p2 ^ c2;
      if (ovf_next) begin
         sum_next = {a15_2, {(WIDTH-1){~a15_2}}};
      end
   end
`else
   assign sum_next = p2 ^ c2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3    <= 1'b0;
         sum3  <= '0;
         cout3 <= 1'b0;
         tag3  <= '0;
      end else if (rdy3) begin
         v3    <= v2;
         sum3  <= sum_next;
         cout3 <= c16_2;
         tag3  <= tag2;
      end
   end

`ifdef CLA_SAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf3 <= 1'b0;
      end else if (rdy3) begin
         ovf3 <= ovf_next;
      end
   end

   assign ovf_out = ovf3;
`endif

   assign out_valid = v3;
   assign sum_out   = sum3;
   assign cout      = cout3;
   assign tag_out   = tag3;

endmodule

// File: tb/tb_cla_pipe_add16.sv
// Self-checking bench for cla_pipe_add16: arithmetic/queue reference model plus directed literal cases.
// Define CLA_SAT_EN to exercise the saturating build.
module tb_cla_pipe_add16;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic        cin;
   logic [3:0]  tag_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum_out;
   logic        cout;
   logic [3:0]  tag_out;
`ifdef CLA_SAT_EN
   logic        ovf_out;
`endif

   cla_pipe_add16 #(.WIDTH(16), .TAG_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_in     (a_in),
      .b_in     (b_in),
      .cin      (cin),
      .tag_in   (tag_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum_out  (sum_out),
      .cout     (cout),
      .tag_out  (tag_out)
`ifdef CLA_SAT_EN
      ,
      .ovf_out  (ovf_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] s;
      logic        co;
      logic        ov;
      logic [3:0]  tag;
      int unsigned cyc;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   int unsigned retired = 0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_sum;
   logic        prev_cout;
   logic [3:0]  prev_tag;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer addition, signed overflow from operand/result signs
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic c, input logic [3:0] t);
      exp_t        e;
      int unsigned full;
      logic [16:0] f17;
      full  = int'(a) + int'(b) + int'(c);
      f17   = full[16:0];
      e.s   = f17[15:0];
      e.co  = f17[16];
      e.ov  = (a[15] == b[15]) && (e.s[15] != a[15]);
      e.tag = t;
      e.cyc = 0;
`ifdef CLA_SAT_EN
      if (e.ov) e.s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      logic exp_ov;
      if (!rst_n) begin
         q.delete();
         prev_stall = 1'b0;
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_sum", 32'(sum_out), 32'd0);
         check("rst_cout", 32'(cout), 32'd0);
         check("rst_tag", 32'(tag_out), 32'd0);
`ifdef CLA_SAT_EN
         check("rst_ovf", 32'(ovf_out), 32'd0);
`endif
      end else begin
         exp_ov = (q.size() != 0) && (cyc - q[0].cyc >= 3);
         check("out_valid", 32'(out_valid), 32'(exp_ov));
         check("in_ready", 32'(in_ready), 32'(!(q.size() == 3 && !out_ready)));
         if (prev_stall) begin
            check("stall_sum", 32'(sum_out), 32'(prev_sum));
            check("stall_cout", 32'(cout), 32'(prev_cout));
            check("stall_tag", 32'(tag_out), 32'(prev_tag));
         end
         if (out_valid && out_ready && q.size() != 0) begin
            e = q.pop_front();
            check("sum", 32'(sum_out), 32'(e.s));
            check("cout", 32'(cout), 32'(e.co));
            check("tag", 32'(tag_out), 32'(e.tag));
`ifdef CLA_SAT_EN
            check("ovf", 32'(ovf_out), 32'(e.ov));
`endif
            retired++;
         end
         if (in_valid && in_ready) begin
            e = model(a_in, b_in, cin, tag_in);
            e.cyc = cyc;
            q.push_back(e);
         end
         prev_stall = out_valid && !out_ready;
         prev_sum   = sum_out;
         prev_cout  = cout;
         prev_tag   = tag_out;
         cyc++;
      end
   end

   task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic c,
                           input logic [3:0] t, input logic [15:0] es, input logic eco,
                           input logic eov);
      int lat;
      @(posedge clk); #1;
      in_valid = 1'b1; a_in = a; b_in = b; cin = c; tag_in = t; out_ready = 1'b1;
      @(negedge clk);
      check("d_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 9;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      check("d_latency", 32'(lat), 32'd3);
      check("d_sum", 32'(sum_out), 32'(es));
      check("d_cout", 32'(cout), 32'(eco));
      check("d_tag", 32'(tag_out), 32'(t));
`ifdef CLA_SAT_EN
      check("d_ovf", 32'(ovf_out), 32'(eov));
`else
      if (eov) check("d_raw_sign_flip", 32'(sum_out[15] ^ a[15]), 32'd1);
`endif
   endtask

   initial begin
      int acc;
      int nvalid;
      int r0;
      logic took;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a_in = '0; b_in = '0; cin = 1'b0; tag_in = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed literal cases
      send_one(16'hFFFF, 16'h0001, 1'b0, 4'h3, 16'h0000, 1'b1, 1'b0);
      send_one(16'h1234, 16'h4321, 1'b1, 4'h5, 16'h5556, 1'b0, 1'b0);
      send_one(16'h0FFF, 16'h0001, 1'b0, 4'h9, 16'h1000, 1'b0, 1'b0);
      send_one(16'hFFFF, 16'h0000, 1'b1, 4'hA, 16'h0000, 1'b1, 1'b0);
`ifdef CLA_SAT_EN
      send_one(16'h7FFF, 16'h0001, 1'b0, 4'h1, 16'h7FFF, 1'b0, 1'b1);
      send_one(16'h8000, 16'hFFFF, 1'b0, 4'h2, 16'h8000, 1'b1, 1'b1);
`else
      send_one(16'h7FFF, 16'h0001, 1'b0, 4'h1, 16'h8000, 1'b0, 1'b1);
      send_one(16'h8000, 16'hFFFF, 1'b0, 4'h2, 16'h7FFF, 1'b1, 1'b1);
`endif
      repeat (4) @(posedge clk);

      // 8 back-to-back transfers
      nvalid = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; a_in = 16'(i); b_in = 16'(16'h00F0 + i); cin = 1'b0; tag_in = 4'(i);
         @(negedge clk);
         check("b2b_in_ready", 32'(in_ready), 32'd1);
         if (out_valid) nvalid++;
      end
      @(posedge clk); #1 in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) nvalid++;
      end
      check("b2b_out_count", 32'(nvalid), 32'd8);

      // Stall: 5 offered with out_ready low, only 3 fit
      @(posedge clk); #1;
      out_ready = 1'b0; acc = 0; r0 = int'(retired);
      in_valid = 1'b1; a_in = 16'h0100; b_in = 16'h0011; cin = 1'b0; tag_in = 4'h8;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk); #1;
         a_in = 16'((acc + 1) * 256); tag_in = 4'(8 + acc);
      end
      @(negedge clk);
      check("stall_accepted", 32'(acc), 32'd3);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1 out_ready = 1'b1;
      for (int i = 0; i < 10 && acc < 5; i++) begin
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk); #1;
         if (acc < 5) begin
            a_in = 16'((acc + 1) * 256); tag_in = 4'(8 + acc);
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("stall_total", 32'(acc), 32'd5);
      check("stall_retired", 32'(int'(retired) - r0), 32'd5);

      // Reset with transactions in flight
      @(posedge clk); #1;
      in_valid = 1'b1; a_in = 16'hAAAA; b_in = 16'h1111; tag_in = 4'hC;
      @(posedge clk); #1;
      a_in = 16'h0F0F; tag_in = 4'hD;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sum", 32'(sum_out), 32'd0);
      check("mid_rst_tag", 32'(tag_out), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) nvalid++;
      end
      check("post_rst_no_stale", 32'(nvalid), 32'd0);

      // Randomized traffic with random backpressure
      in_valid = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk); #1;
         if (!in_valid || took) begin
            in_valid = ($urandom_range(0, 9) < 7);
            a_in     = 16'($urandom);
            b_in     = 16'($urandom);
            cin      = 1'($urandom);
            tag_in   = 4'($urandom);
         end
         out_ready = ($urandom_range(0, 9) < 6);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) @(negedge clk);
      check("final_drained", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
